// File: rtl/vsynth_nco_pkg.sv
// Shared NCO types and widths used by the phase accumulator and phase2sample.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vsynth_nco_pkg;

  // Width of the phase strobe handed to phase2sample.
  localparam int NCO_PHASE_W   = 7;
  // Default accumulator / frequency word width.
  localparam int NCO_ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    GLIDE = 2'd2
  } nco_state_t;

endpackage

// File: rtl/nco_phase_acc_if.sv
// Control and phase-strobe bundle between the NCO controller and the phase accumulator.
// Latency: n/a (wires only).
// Backpressure: none; the strobe is fire-and-forget, one per sample period.
interface nco_phase_acc_if
  import vsynth_nco_pkg::*;
#(
  parameter int ACC_W = NCO_ACC_W_DEF
);
  logic                   enable;
  logic [ACC_W-1:0]       fword;
  logic                   fword_we;
  logic                   glide_en;
  logic                   note_on;
  logic [NCO_PHASE_W-1:0] nco_phase;
  logic                   nco_phase_dv;
  logic                   cycle_wrap;

  modport master (
    output enable, fword, fword_we, glide_en, note_on,
    input  nco_phase, nco_phase_dv, cycle_wrap
  );

  modport slave (
    input  enable, fword, fword_we, glide_en, note_on,
    output nco_phase, nco_phase_dv, cycle_wrap
  );
endinterface

// File: rtl/nco_phase_acc_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV clocks while enabled.
// Latency: tick is combinational from the counter; first tick CLK_DIV cycles after enable.
// Backpressure: none; dropping enable clears the count and discards the pending tick.
module nco_phase_acc_tick_gen #(
  parameter int CLK_DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);
  localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  assign tick_o = enable_i && (div_cnt_q == LAST);

  // Next count: held at zero while stopped, wraps after the last cycle of a period.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!enable_i) begin
      div_cnt_d = '0;
    end else if (tick_o) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end
endmodule

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator with optional portamento on the phase increment and note-on sync.
// Latency: outputs register on the tick-cycle edge (1 clk); strobes exactly CLK_DIV apart.
// Backpressure: none; enable low stops the NCO, drops a pending tick and holds the phase.
module nco_phase_acc
  import vsynth_nco_pkg::*;
#(
  parameter int CLK_DIV     = 1024,
  parameter int ACC_W       = NCO_ACC_W_DEF,
  parameter int GLIDE_SHIFT = 4
) (
  input logic             clk,
  input logic             rst_n,
  nco_phase_acc_if.slave  bus
);
  nco_state_t             state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [ACC_W-1:0]       target_q, target_d;
  logic [ACC_W-1:0]       inc_cur_q, inc_cur_d;
  logic                   sync_pend_q, sync_pend_d;
  logic [NCO_PHASE_W-1:0] phase_q, phase_d;
  logic                   dv_q, dv_d;
  logic                   wrap_q, wrap_d;

  logic                   tick;
  logic                   sync_now;
  logic [ACC_W:0]         sum;
  logic signed [ACC_W:0]  diff;
  logic signed [ACC_W:0]  step;
  logic [ACC_W-1:0]       inc_glide;

  nco_phase_acc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (bus.enable),
    .tick_o   (tick)
  );

  // A note-on landing in the tick cycle itself is honoured by that tick.
  assign sync_now = sync_pend_q | bus.note_on;
  assign sum      = {1'b0, acc_q} + {1'b0, inc_cur_q};

  // Glide step: shifted distance to target, never smaller than one LSB toward it.
  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, inc_cur_q});
    step = diff >>> GLIDE_SHIFT;
    if ((step == '0) && (diff != '0)) begin
      step = diff[ACC_W] ? '1 : (ACC_W+1)'(1);
    end
    inc_glide = inc_cur_q + step[ACC_W-1:0];
  end

  // Next state for accumulator, increment, sync flag, outputs and FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    inc_cur_d   = inc_cur_q;
    phase_d     = phase_q;
    dv_d        = 1'b0;
    wrap_d      = 1'b0;
    target_d    = bus.fword_we ? bus.fword : target_q;
    sync_pend_d = sync_now;
    if (!bus.enable) begin
      state_d = STOP;
    end else if (tick) begin
      acc_d       = sync_now ? '0 : sum[ACC_W-1:0];
      phase_d     = acc_d[ACC_W-1 -: NCO_PHASE_W];
      dv_d        = 1'b1;
      wrap_d      = sum[ACC_W] | sync_now;
      sync_pend_d = 1'b0;
      case (state_q)
        GLIDE: begin
          if (!bus.glide_en) begin
            inc_cur_d = target_q;
            state_d   = RUN;
          end else begin
            inc_cur_d = inc_glide;
            state_d   = (inc_glide == target_q) ? RUN : GLIDE;
          end
        end
        default: begin
          if (!bus.glide_en) begin
            inc_cur_d = target_q;
            state_d   = RUN;
          end else begin
            state_d   = (target_q != inc_cur_q) ? GLIDE : RUN;
          end
        end
      endcase
    end else if (state_q == STOP) begin
      state_d = RUN;
    end
  end

  // Single state register for FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STOP;
      acc_q       <= '0;
      target_q    <= '0;
      inc_cur_q   <= '0;
      sync_pend_q <= 1'b0;
      phase_q     <= '0;
      dv_q        <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      target_q    <= target_d;
      inc_cur_q   <= inc_cur_d;
      sync_pend_q <= sync_pend_d;
      phase_q     <= phase_d;
      dv_q        <= dv_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.nco_phase    = phase_q;
  assign bus.nco_phase_dv = dv_q;
  assign bus.cycle_wrap   = wrap_q;
endmodule

// File: tb/tb_nco_phase_acc.sv
// Bench for nco_phase_acc: directed scenarios plus a randomized segment against an arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nco_phase_acc;
  import vsynth_nco_pkg::*;

  localparam int CLK_DIV = 8;
  localparam int ACC_W   = 24;
  localparam int GS      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_phase_acc_if #(.ACC_W(ACC_W)) bus ();

  nco_phase_acc #(.CLK_DIV(CLK_DIV), .ACC_W(ACC_W), .GLIDE_SHIFT(GS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_dv_cyc = 0;
  bit          have_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: full-precision accumulator and increment as plain integers.
  longint m_acc, m_inc, m_target;
  bit     m_sync, m_gliding;
  int     exp_phase;
  bit     exp_wrap;
  int     obs_phase;
  bit     obs_wrap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_inc = 0; m_target = 0; m_sync = 0; m_gliding = 0; have_last = 0;
  endtask

  task automatic model_tick(input bit glide);
    longint s, d, st;
    s        = m_acc + m_inc;
    exp_wrap = (s >= (longint'(1) << ACC_W)) || m_sync;
    m_acc    = m_sync ? 0 : s % (longint'(1) << ACC_W);
    m_sync   = 0;
    exp_phase = int'(m_acc >> (ACC_W - 7));
    if (!glide) begin
      m_inc = m_target; m_gliding = 0;
    end else if (!m_gliding) begin
      if (m_target != m_inc) m_gliding = 1;
    end else begin
      d  = m_target - m_inc;
      st = d >>> GS;
      if (st == 0) st = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
      m_inc = m_inc + st;
      if (m_inc == m_target) m_gliding = 0;
    end
  endtask

  // Waits (bounded) for a strobe at the current or a later falling edge.
  task automatic wait_dv(input string tag, output bit ok);
    int n;
    n = 0;
    while (bus.nco_phase_dv !== 1'b1 && n < 3 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.nco_phase_dv === 1'b1);
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic tick_check(input string tag);
    bit ok;
    wait_dv(tag, ok);
    model_tick(bus.glide_en);
    if (ok) begin
      obs_phase = int'(bus.nco_phase);
      obs_wrap  = bus.cycle_wrap;
      check({tag, "_phase"}, 32'(bus.nco_phase), 32'(exp_phase));
      check({tag, "_wrap"}, 32'(bus.cycle_wrap), 32'(exp_wrap));
      if (have_last) check({tag, "_period"}, cyc - last_dv_cyc, 32'(CLK_DIV));
      last_dv_cyc = cyc;
      have_last   = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic write_fword(input logic [ACC_W-1:0] v);
    bus.fword = v; bus.fword_we = 1'b1;
    @(negedge clk);
    bus.fword_we = 1'b0;
    m_target = longint'(v);
  endtask

  task automatic pulse_note();
    bus.note_on = 1'b1;
    @(negedge clk);
    bus.note_on = 1'b0;
    m_sync = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    bit seen;
    int held;
    logic [ACC_W-1:0] nf;

    bus.enable = 1'b0; bus.fword = '0; bus.fword_we = 1'b0;
    bus.glide_en = 1'b0; bus.note_on = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(bus.nco_phase), 32'd0);
    check("rst_dv", 32'(bus.nco_phase_dv), 32'd0);
    check("rst_wrap", 32'(bus.cycle_wrap), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    repeat (3 * CLK_DIV) begin @(negedge clk); if (bus.nco_phase_dv === 1'b1) seen = 1'b1; end
    check("stop_no_dv", 32'(seen), 32'd0);

    // 1: steady increment of one phase step per period
    write_fword(24'h020000);
    bus.enable = 1'b1;
    tick_check("t1_warm");
    pulse_note();
    tick_check("t1_sync");
    check("dv_pulse", 32'(bus.nco_phase_dv), 32'd0);
    for (int i = 1; i <= 128; i++) begin
      tick_check("t1");
      check("t1_seq", 32'(obs_phase), 32'(i % 128));
      check("t1_wrapseq", 32'(obs_wrap), 32'(i == 128));
    end

    // 2: note-on sync at phase 40
    repeat (40) tick_check("t2_run");
    check("t2_at40", 32'(obs_phase), 32'd40);
    pulse_note();
    tick_check("t2_sync");
    check("t2_phase0", 32'(obs_phase), 32'd0);
    check("t2_wrap1", 32'(obs_wrap), 32'd1);
    tick_check("t2_next");
    check("t2_phase1", 32'(obs_phase), 32'd1);

    // 4: frequency write in the tick cycle takes effect two ticks later
    nf = ACC_W'($urandom_range(32'h0FFFFF, 32'h040000));
    repeat (CLK_DIV - 2) @(negedge clk);
    bus.fword = nf; bus.fword_we = 1'b1;
    @(negedge clk);
    bus.fword_we = 1'b0;
    tick_check("t4_a");
    m_target = longint'(nf);
    check("t4_a_old", 32'(obs_phase), 32'd2);
    tick_check("t4_b");
    check("t4_b_old", 32'(obs_phase), 32'd3);
    tick_check("t4_c");

    // Randomized segment: frequency writes, glide toggling, note-on
    for (int i = 0; i < 40; i++) begin
      bus.glide_en = 1'($urandom % 2);
      if ($urandom % 3 == 0) write_fword(ACC_W'($urandom));
      if ($urandom % 8 == 0) pulse_note();
      tick_check("rnd");
    end

    // 5: enable low for 20 clocks holds the phase; restart is one full period later
    held = obs_phase;
    bus.enable = 1'b0;
    m_gliding = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.nco_phase_dv === 1'b1) seen = 1'b1; end
    check("t5_no_dv", 32'(seen), 32'd0);
    check("t5_held", 32'(bus.nco_phase), 32'(held));
    check("t5_state", 32'(dut.state_q), 32'(STOP));
    have_last = 1'b0;
    bus.enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.nco_phase_dv !== 1'b1 && n < 4 * CLK_DIV);
    check("t5_restart", 32'(n), 32'(CLK_DIV));
    tick_check("t5_resume");

    // 3: glide from zero toward 0x001000
    bus.enable = 1'b0; bus.glide_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.glide_en = 1'b1;
    write_fword(24'h001000);
    bus.enable = 1'b1;
    tick_check("t3_enter");
    check("t3_state_glide", 32'(dut.state_q), 32'(GLIDE));
    check("t3_inc0", 32'(dut.inc_cur_q), 32'h0);
    tick_check("t3_s1");
    check("t3_inc1", 32'(dut.inc_cur_q), 32'h000100);
    tick_check("t3_s2");
    check("t3_inc2", 32'(dut.inc_cur_q), 32'h0001F0);
    tick_check("t3_s3");
    check("t3_inc3", 32'(dut.inc_cur_q), 32'h0002D1);
    k = 0;
    while (m_gliding && k < 200) begin
      tick_check("t3");
      check("t3_inc", 32'(dut.inc_cur_q), 32'(m_inc));
      k++;
    end
    check("t3_final_inc", 32'(dut.inc_cur_q), 32'h001000);
    check("t3_state_run", 32'(dut.state_q), 32'(RUN));

    // 6: asynchronous reset in the middle of a glide
    write_fword(24'h800000);
    repeat (3) tick_check("t6_glide");
    check("t6_in_glide", 32'(dut.state_q), 32'(GLIDE));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_phase", 32'(bus.nco_phase), 32'd0);
    check("t6_dv", 32'(bus.nco_phase_dv), 32'd0);
    check("t6_wrap", 32'(bus.cycle_wrap), 32'd0);
    check("t6_acc", 32'(dut.acc_q), 32'd0);
    check("t6_inc", 32'(dut.inc_cur_q), 32'd0);
    check("t6_state", 32'(dut.state_q), 32'(STOP));
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (3 * CLK_DIV) begin @(negedge clk); if (bus.nco_phase_dv === 1'b1) seen = 1'b1; end
    check("t6_idle_dv", 32'(seen), 32'd0);
    check("t6_idle_state", 32'(dut.state_q), 32'(STOP));
    bus.enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.nco_phase_dv !== 1'b1 && n < 4 * CLK_DIV);
    check("t6_restart", 32'(n), 32'(CLK_DIV));
    tick_check("t6_first");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
